mul_share_ctrl: RTL
===================

// Module: mul_share_ctrl
// PURPOSE
//  Sequencer/arbiter sharing one registered 8x8 multiplier datapath between two requesters.
//  - Datapath: enabled operand registers A/B, a multiplier, and a 16-bit product register.
//  - Accepts operand pairs via valid/ready and arbitrates round-robin.
//  - Drives operand-register enables and operand values, then returns the product with a requester ID.
// PARAMETERS
//  OP_W   8   operand width; product width is 2*OP_W
//  NREQ   2   requester count; fixed at 2, other values are out of scope
// PORTS
//  clk_system    in   1       single system clock, rising edge
//  rst_system    in   1       reset; synchronous, active-high
//  req_valid     in   NREQ    requester i presents an operand pair
//  req_a         in   NREQ*OP_W  packed operand A; slice i belongs to requester i
//  req_b         in   NREQ*OP_W  packed operand B; slice i belongs to requester i
//  req_ready     out  NREQ    one-hot accept; handshake occurs when valid and ready are both high
//  mul_ea        out  1       load enable for operand register A
//  mul_eb        out  1       load enable for operand register B
//  mul_a         out  OP_W    D input of operand register A
//  mul_b         out  OP_W    D input of operand register B
//  mul_product   in   2*OP_W  Q output of the product register
//  rsp_valid     out  1       response available
//  rsp_ready     in   1       consumer accepts the response
//  rsp_id        out  1       index of the requester that owns rsp_data
//  rsp_data      out  2*OP_W  product
//  busy          out  1       high in every state except IDLE
// BEHAVIOUR
//  FSM states: IDLE -> LOAD -> MULT -> RESP -> IDLE.
//  - IDLE: if any req_valid is set, the arbiter picks a winner w.
//    req_ready[w]=1, mul_ea=mul_eb=1, mul_a=req_a[w], mul_b=req_b[w] (all combinational).
//    Next state is LOAD; w is stored as the owner.
//  - LOAD: operand registers now hold the pair; the product register captures at this edge.
//    mul_ea=mul_eb=0. Next state is MULT.
//  - MULT: mul_product is valid. rsp_data<=mul_product, rsp_id<=owner, rsp_valid<=1. Next state is RESP.
//  - RESP: hold rsp_valid, rsp_id and rsp_data stable until rsp_ready=1, then go to IDLE.
//    Back-to-back operation is not supported: a new accept is possible only in the cycle after IDLE is re-entered.
//  Latency: accept edge to rsp_valid=1 is 3 clocks; sustained throughput is 1 result per 4 clocks.
//  Arbitration: round-robin with priority pointer ptr.
//  - Reset sets ptr=0.
//  - With both requesters valid, the winner is ptr, and ptr toggles after each grant.
//  - With one requester valid, it wins and ptr becomes the other index.
//  req_ready is zero outside IDLE. A requester must hold valid and data stable until accepted.
//  Width: product is unsigned 2*OP_W and cannot overflow (255*255=65025).
//  Reset (synchronous, any state, including mid-operation):
//  - state=IDLE, ptr=0, owner=0.
//  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, req_ready=0, mul_ea=mul_eb=0, mul_a=mul_b=0.
//  - An in-flight operation is discarded and no response is produced.
//  - rst_system also resets the datapath registers; this block does not assume their contents.
//  Boundaries:
//  - rsp_ready may already be high when entering RESP: the response completes in one cycle.
//  - req_valid deasserted before accept: no grant. X on unselected operands is ignored.
// CONFIGURATION
//  Macro MUL_SHARE_PERF_CNT_EN. When defined, adds per-requester outputs:
//  - done_cnt0 and done_cnt1 (16 bit each).
//  - A counter increments on each rsp_valid&&rsp_ready handshake for rsp_id, wraps 0xFFFF->0, and resets to 0.
//  When undefined, these ports and counters do not exist and behaviour is otherwise identical.
// STRUCTURE
//  Package mul_share_pkg:
//  - typedef enum logic[1:0] {IDLE, LOAD, MULT, RESP} state_t.
//  - localparams OP_W_DEF=8 and NREQ_DEF=2.
//  - Product-width function.
//  Sub-module mul_rr_arb:
//  - 2-way round-robin arbiter; inputs req, advance, clk_system, rst_system; outputs gnt (one-hot) and idx.
//  - Holds ptr.
//  The FSM, the operand mux and the response registers live in mul_share_ctrl.
// TESTING
//  The bench instantiates this block with the operand-register/multiplier/product-register datapath model.
//  1. Reset, then req0 with a=12, b=10 -> req_ready=01 that cycle; 3 clocks later rsp_valid=1, rsp_id=0, rsp_data=120.
//  2. Both valid at once: r0 a=3,b=4; r1 a=255,b=255 -> grants r0 then r1;
//     responses (0,12) then (1,65025); ptr then favours r0.
//  3. rsp_ready held low for 5 clocks -> rsp fields stable; no req_ready asserted; busy=1 throughout.
//  4. rst_system pulsed while in MULT -> next cycle all outputs 0 and state IDLE; no stale response appears.
//  5. req1 alone repeatedly, with rsp_ready tied high -> accepts every 4 clocks; a=0,b=200 gives rsp_data=0.
//  6. With MUL_SHARE_PERF_CNT_EN defined: 3 responses for r0 and 2 for r1 -> done_cnt0=3, done_cnt1=2;
//     a preloaded 0xFFFF wraps to 0.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the mul_share_ctrl block.
//   state_t  : sequencer states IDLE -> LOAD -> MULT -> RESP
//   OP_W_DEF : default operand width
//   NREQ_DEF : requester count (fixed at 2)
//   prod_w() : product width for a given operand width
package mul_share_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, MULT, RESP} state_t;

  localparam int unsigned OP_W_DEF = 8;
  localparam int unsigned NREQ_DEF = 2;

  function automatic int unsigned prod_w(input int unsigned op_w);
    return 2 * op_w;
  endfunction

endpackage

// File: rtl/mul_rr_arb.sv
// Two-way round-robin arbiter holding the priority pointer.
//   clk_system : clock, rising edge
//   rst_system : synchronous active-high reset (ptr -> 0)
//   req        : request vector
//   advance    : a grant is being taken this cycle; update the pointer
//   gnt        : one-hot grant (zero when no request)
//   idx        : index of the granted requester
module mul_rr_arb (
  input  logic       clk_system,
  input  logic       rst_system,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       idx
);

  logic ptr;

  always_comb begin
    idx = 1'b0;
    gnt = 2'b00;
    if (req == 2'b11) begin
      idx = ptr;
    end else begin
      idx = req[1];
    end
    if (req != 2'b00) begin
      gnt = idx ? 2'b10 : 2'b01;
    end
  end

  // After any grant the other requester gets priority, whether or not it
  // was requesting.
  always_ff @(posedge clk_system) begin
    if (rst_system) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~idx;
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Sequencer/arbiter sharing one registered multiplier datapath between two
// requesters. Operands are granted round-robin, loaded into the external
// operand registers, and the registered product is returned with the owner id.
//   clk_system  : clock, rising edge
//   rst_system  : synchronous active-high reset
//   req_valid   : per-requester operand pair valid
//   req_a/req_b : packed operands, slice i belongs to requester i
//   req_ready   : one-hot accept (IDLE only)
//   mul_ea/eb   : operand register load enables
//   mul_a/mul_b : operand register D inputs
//   mul_product : product register Q output
//   rsp_valid/rsp_ready/rsp_id/rsp_data : response handshake
//   busy        : high outside IDLE
// Optional: define MUL_SHARE_PERF_CNT_EN to add done_cnt0/done_cnt1, 16-bit
// wrapping counts of completed responses per requester.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int unsigned OP_W = OP_W_DEF,
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic                    clk_system,
  input  logic                    rst_system,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*OP_W-1:0]    req_a,
  input  logic [NREQ*OP_W-1:0]    req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    mul_ea,
  output logic                    mul_eb,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  input  logic [prod_w(OP_W)-1:0] mul_product,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [prod_w(OP_W)-1:0] rsp_data,
  output logic                    busy
`ifdef MUL_SHARE_PERF_CNT_EN
  ,
  output logic [15:0]             done_cnt0,
  output logic [15:0]             done_cnt1
`endif
);

  state_t     state;
  state_t     state_nxt;
  logic       owner;
  logic       advance;
  logic [1:0] gnt;
  logic       idx;

  mul_rr_arb u_arb (
    .clk_system (clk_system),
    .rst_system (rst_system),
    .req        (req_valid),
    .advance    (advance),
    .gnt        (gnt),
    .idx        (idx)
  );

  // Grants are suppressed while reset is asserted so a requester never sees
  // a handshake that the sequencer then discards.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    mul_ea    = 1'b0;
    mul_eb    = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if ((|req_valid) && !rst_system) begin
          req_ready = gnt;
          mul_ea    = 1'b1;
          mul_eb    = 1'b1;
          mul_a     = idx ? req_a[2*OP_W-1:OP_W] : req_a[OP_W-1:0];
          mul_b     = idx ? req_b[2*OP_W-1:OP_W] : req_b[OP_W-1:0];
          advance   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD:    state_nxt = MULT;
      MULT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_system) begin
    if (rst_system) begin
      state     <= IDLE;
      owner     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        owner <= idx;
      end
      if (state == MULT) begin
        rsp_data  <= mul_product;
        rsp_id    <= owner;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef MUL_SHARE_PERF_CNT_EN
  always_ff @(posedge clk_system) begin
    if (rst_system) begin
      done_cnt0 <= '0;
      done_cnt1 <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_id) begin
        done_cnt1 <= done_cnt1 + 16'd1;
      end else begin
        done_cnt0 <= done_cnt0 + 16'd1;
      end
    end
  end
`endif

endmodule
